// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry
// Scans a 4x4 active-low hex keypad, debounces each press and release, and
// shifts every accepted hex digit into a 32-bit entry register (newest digit
// in [3:0]). Exactly one digit is accepted per physical press.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   clr        synchronous clear of the entry register and digit count
//   col[3:0]   keypad column drive, active-low, one-cold
//   value[31:0] entry register
//   key_code   hex code of the last accepted key
//   key_valid  one-cycle strobe per accepted key
//   digit_cnt  digits entered, saturating at 8
//
// Build option: define KEYPAD_AUTOREPEAT_EN to re-emit the held key every
// REPEAT_TICKS scan ticks while it stays pressed.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [31:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [3:0]  digit_cnt
);

    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_TICKS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_TICKS);
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        ACCEPT   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] p);
        case (p)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    // Index of the single low row line.
    function automatic logic [1:0] low_index(input logic [3:0] p);
        case (p)
            4'b1110: low_index = 2'd0;
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    // Physical key position to hex code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'h0;
            4'b11_01: key_map = 4'hF;
            4'b11_10: key_map = 4'hE;
            4'b11_11: key_map = 4'hD;
            default:  key_map = 4'h0;
        endcase
    endfunction

    // Column index to active-low one-cold drive pattern.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    col_drive = 4'b1110;
            2'd1:    col_drive = 4'b1101;
            2'd2:    col_drive = 4'b1011;
            2'd3:    col_drive = 4'b0111;
            default: col_drive = 4'b1110;
        endcase
    endfunction

    logic [3:0]        row_meta_r, rs_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    state_t            state_r, state_nx;
    logic [1:0]        col_idx_r, col_idx_nx;
    logic [3:0]        latch_r, latch_nx;
    logic [DEB_W-1:0]  deb_r, deb_nx, deb_inc_s;
    logic [DEB_W-1:0]  rel_r, rel_nx, rel_inc_s;
    logic [3:0]        code_s;
    logic [31:0]       value_r;
    logic [3:0]        key_code_r, digit_cnt_r;
    logic              key_valid_r;
    logic [3:0]        col_r;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0]  rep_r, rep_nx, rep_inc_s;
`endif

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign deb_inc_s = deb_r + {{(DEB_W-1){1'b0}}, 1'b1};
    assign rel_inc_s = rel_r + {{(DEB_W-1){1'b0}}, 1'b1};
    assign code_s    = key_map(low_index(latch_r), col_idx_r);
`ifdef KEYPAD_AUTOREPEAT_EN
    assign rep_inc_s = rep_r + {{(REP_W-1){1'b0}}, 1'b1};
`endif

    // Two-flop synchronizer for the asynchronous row lines; idles released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_r <= 4'hF;
            rs_r       <= 4'hF;
        end else begin
            row_meta_r <= row;
            rs_r       <= row_meta_r;
        end
    end

    // Free-running scan tick divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    // FSM state and scan/debounce bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= SCAN;
            col_idx_r <= 2'd0;
            latch_r   <= 4'hF;
            deb_r     <= '0;
            rel_r     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_r     <= '0;
`endif
        end else begin
            state_r   <= state_nx;
            col_idx_r <= col_idx_nx;
            latch_r   <= latch_nx;
            deb_r     <= deb_nx;
            rel_r     <= rel_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_r     <= rep_nx;
`endif
        end
    end

    // Next-state logic; every decision is taken only on scan ticks.
    always_comb begin
        state_nx   = state_r;
        col_idx_nx = col_idx_r;
        latch_nx   = latch_r;
        deb_nx     = deb_r;
        rel_nx     = rel_r;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nx     = rep_r;
`endif
        case (state_r)
            SCAN: begin
                if (tick_s) begin
                    if (one_low(rs_r)) begin
                        latch_nx = rs_r;
                        deb_nx   = '0;
                        state_nx = DEBOUNCE;
                    end else begin
                        // Idle or multi-row ghosting: keep rotating.
                        col_idx_nx = col_idx_r + 2'd1;
                    end
                end else begin
                    state_nx = SCAN;
                end
            end
            DEBOUNCE: begin
                if (tick_s) begin
                    if (rs_r == latch_r) begin
                        deb_nx = deb_inc_s;
                        if (deb_inc_s == DEB_DONE) begin
                            state_nx = ACCEPT;
                        end else begin
                            state_nx = DEBOUNCE;
                        end
                    end else begin
                        state_nx   = SCAN;
                        col_idx_nx = col_idx_r + 2'd1;
                    end
                end else begin
                    state_nx = DEBOUNCE;
                end
            end
            ACCEPT: begin
                state_nx = RELEASE;
                rel_nx   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_nx   = '0;
`endif
            end
            RELEASE: begin
                if (tick_s) begin
                    if (rs_r == 4'hF) begin
                        rel_nx = rel_inc_s;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_nx = '0;
`endif
                        if (rel_inc_s == DEB_DONE) begin
                            state_nx = SCAN;
                        end else begin
                            state_nx = RELEASE;
                        end
                    end else begin
                        rel_nx = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rs_r == latch_r) begin
                            if (rep_inc_s == REP_DONE) begin
                                rep_nx   = '0;
                                state_nx = ACCEPT;
                            end else begin
                                rep_nx = rep_inc_s;
                            end
                        end else begin
                            rep_nx = '0;
                        end
`endif
                    end
                end else begin
                    state_nx = RELEASE;
                end
            end
            default: begin
                state_nx = SCAN;
            end
        endcase
    end

    // Registered outputs; clr overrides the shift but not the strobe/code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r       <= 4'b1110;
            value_r     <= 32'h0000_0000;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            digit_cnt_r <= 4'd0;
        end else begin
            col_r <= col_drive(col_idx_nx);
            if (state_r == ACCEPT) begin
                key_valid_r <= 1'b1;
                key_code_r  <= code_s;
            end else begin
                key_valid_r <= 1'b0;
            end
            if (clr) begin
                value_r     <= 32'h0000_0000;
                digit_cnt_r <= 4'd0;
            end else if (state_r == ACCEPT) begin
                value_r <= {value_r[27:0], code_s};
                if (digit_cnt_r != 4'd8) begin
                    digit_cnt_r <= digit_cnt_r + 4'd1;
                end else begin
                    digit_cnt_r <= digit_cnt_r;
                end
            end else begin
                value_r <= value_r;
            end
        end
    end

    assign col       = col_r;
    assign value     = value_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign digit_cnt = digit_cnt_r;

endmodule

// File: tb/tb_hex_keypad_entry.sv
module tb_hex_keypad_entry;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic        clr = 1'b0;
    logic [3:0]  col;
    logic [31:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  digit_cnt;

    int errors = 0;
    int checks = 0;
    int kv_count = 0;
    logic kv_prev = 1'b0;
    logic consec = 1'b0;

    // Keypad model: pressed key pulls its row low while its column is driven.
    logic       press_en = 1'b0;
    logic       glitch = 1'b0;
    logic       two_rows = 1'b0;
    logic [1:0] pr = 2'd0;
    logic [1:0] pr2 = 2'd0;
    logic [1:0] pc = 2'd0;

    hex_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
        .clk(clk), .rst(rst), .row(row), .clr(clr), .col(col), .value(value),
        .key_code(key_code), .key_valid(key_valid), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        if (press_en && !glitch && col[pc] == 1'b0) begin
            row[pr] = 1'b0;
            if (two_rows) row[pr2] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (key_valid) kv_count <= kv_count + 1;
        if (key_valid && kv_prev) consec <= 1'b1;
        kv_prev <= key_valid;
    end

    task automatic wait_ticks(input int n);
        repeat (n * SD) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_hold(input logic [1:0] r, input logic [1:0] c, input int hold, input int rel);
        @(negedge clk);
        pr = r; pc = c; press_en = 1'b1;
        wait_ticks(hold);
        press_en = 1'b0;
        wait_ticks(rel);
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%h exp=e", col); end
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value got=%h exp=0", value); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", digit_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col [4];
        exp_col[0] = 4'hE; exp_col[1] = 4'hD; exp_col[2] = 4'hB; exp_col[3] = 4'h7;
        for (int k = 1; k <= 40; k++) begin
            repeat (SD) @(posedge clk);
            @(negedge clk);
            checks++;
            if (col !== exp_col[k % 4]) begin
                errors++; $display("FAIL idle_col tick=%0d got=%h exp=%h", k, col, exp_col[k % 4]);
            end
        end
        checks++; if (kv_count !== 0) begin errors++; $display("FAIL idle_valid got=%0d exp=0", kv_count); end
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL idle_value got=%h exp=0", value); end
    endtask

    task automatic test_single_key();
        int base;
        base = kv_count;
        press_hold(2'd1, 2'd2, 20, 8);
        checks++; if (kv_count - base !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", kv_count - base); end
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL single_code got=%h exp=6", key_code); end
        checks++; if (value !== 32'h0000_0006) begin errors++; $display("FAIL single_value got=%h exp=00000006", value); end
        checks++; if (digit_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", digit_cnt); end
    endtask

    task automatic test_nine_digits();
        int base;
        pulse_clr();
        base = kv_count;
        for (int k = 1; k <= 9; k++) begin
            press_hold(2'((k - 1) / 3), 2'((k - 1) % 3), 12, 8);
        end
        checks++; if (kv_count - base !== 9) begin errors++; $display("FAIL nine_pulses got=%0d exp=9", kv_count - base); end
        checks++; if (value !== 32'h2345_6789) begin errors++; $display("FAIL nine_value got=%h exp=23456789", value); end
        checks++; if (digit_cnt !== 4'd8) begin errors++; $display("FAIL nine_cnt got=%0d exp=8", digit_cnt); end
    endtask

    task automatic test_bounce();
        int base;
        bit seen;
        pulse_clr();
        base = kv_count;
        pr = 2'd1; pc = 2'd1; press_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            glitch = (i % 2 == 1);
            wait_ticks(1);
        end
        glitch = 1'b0;
        checks++; if (kv_count - base !== 0) begin errors++; $display("FAIL bounce_quiet got=%0d exp=0", kv_count - base); end
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        press_en = 1'b0;
        wait_ticks(8);
        checks++; if (kv_count - base !== 1) begin errors++; $display("FAIL bounce_pulses got=%0d exp=1", kv_count - base); end
        checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL bounce_code got=%h exp=5", key_code); end
    endtask

    task automatic test_clr_accept();
        int base;
        bit seen;
        base = kv_count;
        pr = 2'd0; pr2 = 2'd1; pc = 2'd0; two_rows = 1'b1;
        press_hold(2'd0, 2'd0, 12, 6);
        two_rows = 1'b0;
        checks++; if (kv_count - base !== 0) begin errors++; $display("FAIL ghost_pulses got=%0d exp=0", kv_count - base); end
        @(negedge clk);
        clr = 1'b1; pr = 2'd0; pc = 2'd3; press_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL clr_accept_timeout got=no_strobe exp=strobe");
        end else begin
            checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL clr_code got=%h exp=a", key_code); end
            checks++; if (value !== 32'h0) begin errors++; $display("FAIL clr_value got=%h exp=0", value); end
            checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", digit_cnt); end
        end
        press_en = 1'b0; clr = 1'b0;
        wait_ticks(8);
    endtask

    task automatic test_autorepeat();
        int base;
        bit seen;
        int exp_n;
        logic [31:0] exp_v;
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_n = 3; exp_v = 32'h0000_0FFF;
`else
        exp_n = 1; exp_v = 32'h0000_000F;
`endif
        pulse_clr();
        base = kv_count;
        pr = 2'd3; pc = 2'd1; press_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL repeat_first got=no_strobe exp=strobe"); end
        wait_ticks(12);
        press_en = 1'b0;
        wait_ticks(8);
        checks++; if (kv_count - base !== exp_n) begin errors++; $display("FAIL repeat_pulses got=%0d exp=%0d", kv_count - base, exp_n); end
        checks++; if (value !== exp_v) begin errors++; $display("FAIL repeat_value got=%h exp=%h", value, exp_v); end
        checks++; if (digit_cnt !== 4'(exp_n)) begin errors++; $display("FAIL repeat_cnt got=%0d exp=%0d", digit_cnt, exp_n); end
        checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL repeat_code got=%h exp=f", key_code); end
    endtask

    task automatic test_strobe_width();
        checks++;
        if (consec !== 1'b0) begin errors++; $display("FAIL strobe_width got=consecutive exp=single_cycle"); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_nine_digits();
        test_bounce();
        test_clr_accept();
        test_autorepeat();
        test_strobe_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Input-side counterpart to the seven-segment display path: scans a 4x4 hex keypad, debounces presses, and shifts each accepted hex digit into a 32-bit entry register. That register drives the display path's 32-bit segment value and the processor's operand/switch inputs. One digit is accepted per physical press. A one-cycle strobe accompanies each accepted key.

## Interface
- SCAN_DIV, 100000: clk cycles per scan tick (1 kHz at 100 MHz); minimum 2.
- DEBOUNCE_TICKS, 10: consecutive stable ticks required to accept a press or a release; minimum 1.
- REPEAT_TICKS, 500: ticks between auto-repeat emissions (used only with the config macro).
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; all state returns to reset values immediately.
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- clr  input  1  synchronous clear of the entry register and digit count.
- col  output 4  keypad column drive, active-low, exactly one bit low at all times.
- value  output 32  entry register; newest digit in [3:0].
- key_code  output 4  hex code of the last accepted key.
- key_valid  output 1  one-cycle strobe per accepted key.
- digit_cnt  output 4  number of digits entered, saturating at 8.

## Operation
- row passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- The tick counter counts 0..SCAN_DIV-1 and asserts tick on the terminal count. It runs continuously from reset.
- Key map, by row r and col c (0 = top/left): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
- FSM states:
  - SCAN: on each tick with rs == 4'hF, rotate the active column 0->1->2->3->0. On a tick with exactly one rs bit low, latch the column and row, clear the debounce counter, and go to DEBOUNCE. If more than one row bit is low, treat it as no press and keep rotating.
  - DEBOUNCE: the column is held. On each tick where rs equals the latched pattern, increment the counter. On any tick where it differs, return to SCAN and resume rotation from the next column. When the counter reaches DEBOUNCE_TICKS, go to ACCEPT.
  - ACCEPT: lasts one cycle. Assert key_valid, update key_code, shift value to {value[27:0], code}, and increment digit_cnt (saturating at 8). Then go to RELEASE.
  - RELEASE: the column is held. Count consecutive ticks with rs == 4'hF. A non-F tick resets the count. At DEBOUNCE_TICKS, return to SCAN.
- clr in any cycle sets value = 0 and digit_cnt = 0. If clr coincides with ACCEPT:
  - clr wins, so value = 0 and digit_cnt = 0.
  - key_valid and key_code still update.
- Digits beyond eight shift the oldest digit out of value[31:28].
- Reset mid-press: the FSM returns to SCAN with col = 4'b1110. A key still held is re-debounced and accepted as a new press.

## Timing
- Reset values: col = 4'b1110, value = 0, key_code = 0, key_valid = 0, digit_cnt = 0, state SCAN, tick and debounce counters 0.
- Press latency:
  - 2 cycles of synchronizer delay.
  - The detecting tick in SCAN, plus DEBOUNCE_TICKS further stable ticks.
  - key_valid asserts in the cycle after the final debounce tick.
  - value, key_code and digit_cnt update in the same edge as key_valid rises and are stable while key_valid is high.
- key_valid is never high for two consecutive cycles.
- col changes only on tick edges.
- All outputs are registered.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In RELEASE, while the latched key stays pressed, a repeat counter advances on each tick.
  - When it reaches REPEAT_TICKS, the FSM re-enters ACCEPT (emitting the same code again) and the repeat counter clears.
  - Release behaviour is unchanged.
- Undefined: the repeat logic is absent, and exactly one key_valid is emitted per press regardless of hold time.

## Test plan
- Reset, then idle (row = F) for 40 ticks -> col cycles E, D, B, 7, E...; value = 0; key_valid never asserts.
- SCAN_DIV = 4, DEBOUNCE_TICKS = 3: press r1c2 (key 6) for 20 ticks, then release -> exactly one key_valid; key_code = 6; value = 32'h0000_0006; digit_cnt = 1.
- Enter 1, 2, ..., 9 as nine separate presses -> value = 32'h2345_6789; digit_cnt = 8.
- Bounce: row toggles stable/unstable every tick for 10 ticks, then is stable -> no key_valid during the bounce; exactly one key_valid after DEBOUNCE_TICKS stable ticks.
- Press with two rows low, then clr asserted in the ACCEPT cycle of a later valid press of key A:
  - Two rows low -> no acceptance.
  - Later press -> key_valid = 1, key_code = A, value = 0, digit_cnt = 0.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_TICKS = 5: hold key F for 3 + 12 ticks -> key_valid pulses at acceptance, +5 ticks and +10 ticks; value = 32'h0000_0FFF. Without the macro -> a single pulse.
